final_addition_accumulator: RTL and testbench
=============================================

// Module: final_addition_accumulator
// PURPOSE
//  Consumes the sum produced by final_addition and accumulates it. Pipeline depth of final_addition is run-time selectable, so this block:
//  - tracks operand tokens through the adder latency;
//  - accumulates the arriving sums;
//  - queues completed results behind a valid/ready output.
//  final_addition has no stall input, so admission is credit-based.
// PARAMETERS
//  WIDTH            16  sum width; equals the final_addition WIDTH
//  PIPE_STAGE_WIDTH 2   bits per final_addition stage; NST = WIDTH/PIPE_STAGE_WIDTH
//  PIPELINE_BITS    3   width of pipes
//  ACC_WIDTH        24  accumulator width (>= WIDTH)
//  FIFO_DEPTH       8   result queue entries (>= NST)
//  SATURATE         0   1: clamp at all-ones; 0: wrap modulo 2^ACC_WIDTH
// PORTS
//  clk        in   1              clock
//  rst        in   1              asynchronous reset, active-high
//  pipes      in   PIPELINE_BITS  same value that drives final_addition.pipes
//  in_valid   in   1              operands presented to final_addition this cycle
//  in_first   in   1              token starts a new accumulation (qualified by in_valid)
//  in_last    in   1              token ends the accumulation; emit result (qualified)
//  in_ready   out  1              upstream may assert in_valid this cycle
//  sum_in     in   WIDTH          final_addition.out
//  out_valid  out  1              result available
//  out_ready  in   1              consumer accepts result
//  acc_out    out  ACC_WIDTH      accumulated result
//  acc_ovf    out  1              result overflowed (wrapped or clamped)
// BEHAVIOUR
//  Reset: all outputs, queue, tag pipe, cfg_lat, acc and ovf go to 0. in_ready=1 on the first cycle after rst falls.
//  Latency L(pipes): number of jj in 1..NST-1 with inv!=0 and jj%inv==0.
//   inv is 5-p for pipes p in 1..4; otherwise inv=pipes.
//   For WIDTH=16: pipes 0,1,2,3,4 give L = 0,1,2,3,7; pipes 5,6,7 give L = 1.
//  Tag pipe: shift register of NST-1 entries carrying {valid,first,last}, written on in_valid && in_ready.
//   Arrival tap is at L; when L=0 the tag arrives the same cycle as it is written.
//   sum_in is sampled on the arrival cycle only.
//  Config: cfg_lat is registered from L(pipes) only while the tag pipe is empty.
//   While any tag is in flight and L(pipes) != cfg_lat, in_ready=0.
//   Changing pipes with tokens in flight is an upstream protocol error; in-flight tags still use cfg_lat.
//  Credit: in_ready=0 when (last-tagged tags in flight + queue count) >= FIFO_DEPTH.
//   in_valid while in_ready=0 is ignored; no tag is written.
//  Accumulate on arrival, with sum_in zero-extended:
//   nxt = first ? sum_in : acc + sum_in, computed at ACC_WIDTH+1 bits; carry bit set -> ovf.
//   SATURATE=1: an overflowed nxt is clamped to all-ones. SATURATE=0: it wraps.
//   ovf is sticky over the accumulation; a first token resets it to this token's carry.
//   first && last in the same token gives a single-term result.
//  Emit on arrival with last: push {nxt, ovf_nxt}; acc and ovf are still updated.
//   Credit guarantees the push never meets a full queue.
//  Queue: FWFT. out_valid = !empty; pop on out_valid && out_ready.
//   Push and pop in the same cycle: count unchanged. Pop when empty: no effect.
//   acc_out and acc_ovf hold the head entry; they are 0 when empty.
//  Reset mid-operation: in-flight tags and queued results are discarded and acc=0. Resumes without a flush.
// STRUCTURE
//  Package final_add_pkg holds:
//   - function fa_latency(pipes, NST), shared with the final_addition bench;
//   - localparam MAX_LAT = NST-1;
//   - the tag struct {valid, first, last}.
//  One sub-module: result_fifo (sync FWFT, FIFO_DEPTH x (ACC_WIDTH+1), async active-high rst).
//  Accumulator, tag pipe and credit counter stay in the top level.
// TESTING
//  Bench instantiates final_addition with this block. Reset is asserted for 2 cycles.
//  1. pipes=0; tokens (first,last) 1+2, then (f,l) 10+20 -> one result acc_out=33 the same cycle as the 2nd token; ovf=0.
//  2. pipes=4; a single token (f,l) 100+23 -> out_valid exactly 7 cycles later, acc_out=123.
//  3. SATURATE=0, ACC_WIDTH=16: (f) 0xFFFF+0, then (l) 1+0 -> acc_out=0, ovf=1.
//     SATURATE=1: same stimulus -> acc_out=0xFFFF, ovf=1.
//  4. out_ready=0; stream 8 single-term tokens at pipes=3 -> in_ready drops when 8 credits are used; none are lost.
//     Releasing out_ready pops them in order.
//  5. pipes 2->3 with 2 tokens in flight -> in_ready=0 until both arrive; the next token uses L=3.
//  6. rst asserted with 3 queued results and 2 in flight -> out_valid=0 next cycle; in_ready=1 after release.

Source files
------------

// File: rtl/final_add_pkg.sv
// Shared types and the final_addition latency rule, used by the accumulator and
// by anything that has to model the adder's run-time pipeline depth.
package final_add_pkg;

  localparam int FA_WIDTH = 16;
  localparam int FA_PSW   = 2;
  localparam int NST      = FA_WIDTH / FA_PSW;
  localparam int MAX_LAT  = NST - 1;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // Stage jj of the adder is registered when jj is a multiple of the pipes-derived stride.
  function automatic int fa_latency(input int pipes, input int nst);
    int inv;
    int lat;
    inv = (pipes >= 1 && pipes <= 4) ? 5 - pipes : pipes;
    lat = 0;
    for (int jj = 1; jj < nst; jj++)
      if (inv != 0 && (jj % inv) == 0) lat++;
    return lat;
  endfunction

endpackage

// File: rtl/final_addition_accumulator_fifo.sv
// First-word-fall-through result queue; head reads as zero while empty.
module result_fifo #(
  parameter  int DW    = 25,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= din_i;

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/final_addition_accumulator.sv
// Accumulates final_addition sums: tags ride alongside the adder latency, results
// are queued, and admission is credit-limited because the adder cannot stall.
module final_addition_accumulator
  import final_add_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int PIPELINE_BITS    = 3,
  parameter int ACC_WIDTH        = 24,
  parameter int FIFO_DEPTH       = 8,
  parameter int SATURATE         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIPELINE_BITS-1:0] pipes,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         sum_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     acc_out,
  output logic                     acc_ovf
);

  localparam int TNST   = WIDTH / PIPE_STAGE_WIDTH;
  localparam int ML     = TNST - 1;
  localparam int LW     = $clog2(TNST);
  localparam int NPIPES = 1 << PIPELINE_BITS;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int UW     = $clog2(ML + FIFO_DEPTH + 1);
  localparam int AW1    = ACC_WIDTH + 1;

  logic [LW-1:0]        lat_tab [NPIPES];
  tag_t [ML-1:0]        tag_q, tag_d;
  logic [LW-1:0]        cfg_lat_q, lat, lat_req;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic                 ovf_q, ovf_d, ovf_nxt;
  logic [AW1-1:0]       sum_w;
  logic                 inflight, accept, push, empty;
  logic [UW-1:0]        last_cnt;
  logic [CW-1:0]        fifo_cnt;
  tag_t                 wr_tag, arr_tag;

  // Latency for every pipes value is folded to a constant table at elaboration.
  for (genvar p = 0; p < NPIPES; p++) begin : g_lat
    assign lat_tab[p] = LW'(fa_latency(p, TNST));
  end

  always_comb begin
    lat_req  = lat_tab[pipes];
    inflight = 1'b0;
    last_cnt = '0;
    for (int i = 0; i < ML; i++) begin
      inflight = inflight | tag_q[i].valid;
      last_cnt = last_cnt + UW'(tag_q[i].valid & tag_q[i].last);
    end
    // An empty pipe adopts the new depth at once so a token issued now uses it.
    lat      = inflight ? cfg_lat_q : lat_req;
    in_ready = !(inflight && (lat_req != cfg_lat_q)) &&
               ((last_cnt + UW'(fifo_cnt)) < UW'(FIFO_DEPTH));
    accept   = in_valid && in_ready;
    wr_tag   = '{valid: accept, first: accept & in_first, last: accept & in_last};

    arr_tag = (lat == '0) ? wr_tag : '0;
    for (int i = 0; i < ML; i++)
      if (lat == LW'(i + 1)) arr_tag = tag_q[i];

    // Entries past the active tap are dropped so the pipe only holds live tokens.
    tag_d    = '0;
    tag_d[0] = (lat != '0) ? wr_tag : '0;
    for (int i = 1; i < ML; i++)
      tag_d[i] = (LW'(i) < lat) ? tag_q[i-1] : '0;
  end

  always_comb begin
    sum_w   = arr_tag.first ? AW1'(sum_in) : {1'b0, acc_q} + AW1'(sum_in);
    acc_nxt = (SATURATE != 0 && sum_w[ACC_WIDTH]) ? '1 : sum_w[ACC_WIDTH-1:0];
    ovf_nxt = sum_w[ACC_WIDTH] | (!arr_tag.first & ovf_q);
    acc_d   = arr_tag.valid ? acc_nxt : acc_q;
    ovf_d   = arr_tag.valid ? ovf_nxt : ovf_q;
    push    = arr_tag.valid & arr_tag.last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q     <= '0;
      cfg_lat_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      cfg_lat_q <= lat;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  result_fifo #(.DW(ACC_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({acc_nxt, ovf_nxt}),
    .pop_i   (out_valid && out_ready),
    .dout_o  ({acc_out, acc_ovf}),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_final_addition_accumulator.sv
// Scoreboard bench: an ideal adder model feeds sum_in, accepted tokens update a
// reference accumulator, and completed results are queued for in-order checking.
module tb_final_addition_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pipes = 3'd0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [15:0] sum_in;
  logic        in_ready, out_valid, acc_ovf;
  logic        out_ready = 1'b0;
  logic [23:0] acc_out;

  logic        v2 = 1'b0, f2 = 1'b0, l2 = 1'b0, r2 = 1'b0;
  logic [15:0] s2 = '0;
  logic [2:0]  p2 = 3'd0;
  logic        w_rdy, w_valid, w_ovf, s_rdy, s_valid, s_ovf;
  logic [15:0] w_acc, s_acc;

  int          ntot = 0, nbad = 0;
  logic [24:0] q[$];
  logic [23:0] exp_acc = '0;
  logic        exp_ovf = 1'b0;

  typedef struct packed {
    logic        vld;
    logic [2:0]  lat;
    logic [15:0] v;
  } hent_t;
  hent_t hist [8];

  always #5 clk = ~clk;

  final_addition_accumulator dut (
    .clk(clk), .rst(rst), .pipes(pipes), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_ready(in_ready), .sum_in(sum_in), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .acc_ovf(acc_ovf));

  final_addition_accumulator #(.ACC_WIDTH(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .pipes(p2), .in_valid(v2), .in_first(f2), .in_last(l2),
    .in_ready(w_rdy), .sum_in(s2), .out_valid(w_valid), .out_ready(r2),
    .acc_out(w_acc), .acc_ovf(w_ovf));

  final_addition_accumulator #(.ACC_WIDTH(16), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .pipes(p2), .in_valid(v2), .in_first(f2), .in_last(l2),
    .in_ready(s_rdy), .sum_in(s2), .out_valid(s_valid), .out_ready(r2),
    .acc_out(s_acc), .acc_ovf(s_ovf));

  function automatic int bench_lat(input logic [2:0] p);
    case (p)
      3'd0: return 0;
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 3;
      3'd4: return 7;
      default: return 1;
    endcase
  endfunction

  // Ideal adder: each operand pair emerges after the depth in force when it was issued.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      for (int k = 7; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= '{vld: in_valid, lat: 3'(bench_lat(pipes)), v: a + b};
    end
  end

  always_comb begin
    sum_in = '0;
    if (in_valid && bench_lat(pipes) == 0) sum_in = a + b;
    for (int k = 1; k < 8; k++)
      if (hist[k-1].vld === 1'b1 && int'(hist[k-1].lat) == k) sum_in = hist[k-1].v;
  end

  task automatic drive(input bit v, input bit f, input bit l, input logic [15:0] x, input logic [15:0] y);
    in_valid = v; in_first = f; in_last = l; a = x; b = y;
  endtask

  // One clock: record acceptance in the reference model, return after the edge.
  task automatic step(output bit acc);
    logic [24:0] n;
    logic [15:0] s;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      s = a + b;
      n = in_first ? {9'b0, s} : {1'b0, exp_acc} + {9'b0, s};
      exp_ovf = n[24] | (!in_first & exp_ovf);
      exp_acc = n[23:0];
      if (in_last) q.push_back({exp_acc, exp_ovf});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1;
    step(acc);
    step(acc);
    rst = 1'b0;
    #1;
    ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
    ntot++; if ({acc_out, acc_ovf} !== 25'd0) begin nbad++; $display("FAIL rst_out got=%h want=0", {acc_out, acc_ovf}); end
    ntot++; if (in_ready !== 1'b1) begin nbad++; $display("FAIL rst_ready got=%0b want=1", in_ready); end
    ntot++; if ({w_valid, s_valid} !== 2'b00) begin nbad++; $display("FAIL rst_valid2 got=%b want=00", {w_valid, s_valid}); end
  endtask

  task automatic test_two_term();
    bit acc;
    logic [24:0] e;
    pipes = 3'd0; out_ready = 1'b0;
    drive(1, 1, 0, 16'd1, 16'd2);
    step(acc);
    ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t1_early got=%0b want=0", out_valid); end
    drive(1, 0, 1, 16'd10, 16'd20);
    step(acc);
    ntot++; if (out_valid !== 1'b1) begin nbad++; $display("FAIL t1_valid got=%0b want=1", out_valid); end
    e = (q.size() != 0) ? q.pop_front() : 'x;
    ntot++; if ({acc_out, acc_ovf} !== e) begin nbad++; $display("FAIL t1_result got=%h want=%h", {acc_out, acc_ovf}, e); end
    ntot++; if (acc_out !== 24'd33) begin nbad++; $display("FAIL t1_sum got=%0d want=33", acc_out); end
    out_ready = 1'b1;
    step(acc);
    out_ready = 1'b0;
    ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t1_pop got=%0b want=0", out_valid); end
  endtask

  task automatic test_latency7();
    bit acc;
    logic [24:0] e;
    pipes = 3'd4;
    drive(1, 1, 1, 16'd100, 16'd23);
    step(acc);
    ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t2_c0 got=%0b want=0", out_valid); end
    for (int i = 1; i < 7; i++) begin
      step(acc);
      ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t2_early c=%0d got=%0b want=0", i, out_valid); end
    end
    step(acc);
    ntot++; if (out_valid !== 1'b1) begin nbad++; $display("FAIL t2_valid got=%0b want=1", out_valid); end
    e = (q.size() != 0) ? q.pop_front() : 'x;
    ntot++; if ({acc_out, acc_ovf} !== e || acc_out !== 24'd123) begin nbad++; $display("FAIL t2_result got=%h want=%h", {acc_out, acc_ovf}, e); end
    out_ready = 1'b1;
    step(acc);
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    bit acc;
    v2 = 1; f2 = 1; l2 = 0; s2 = 16'hFFFF;
    step(acc);
    ntot++; if (w_valid !== 1'b0) begin nbad++; $display("FAIL t3_early got=%0b want=0", w_valid); end
    v2 = 1; f2 = 0; l2 = 1; s2 = 16'h0001;
    step(acc);
    ntot++; if ({w_valid, w_acc, w_ovf} !== {1'b1, 16'h0000, 1'b1}) begin nbad++; $display("FAIL t3_wrap got=%b/%h/%b want=1/0000/1", w_valid, w_acc, w_ovf); end
    ntot++; if ({s_valid, s_acc, s_ovf} !== {1'b1, 16'hFFFF, 1'b1}) begin nbad++; $display("FAIL t3_sat got=%b/%h/%b want=1/ffff/1", s_valid, s_acc, s_ovf); end
    // Pop the overflowed result while a fresh single-term token clears the sticky flag.
    r2 = 1; v2 = 1; f2 = 1; l2 = 1; s2 = 16'd5;
    step(acc);
    ntot++; if ({w_valid, w_acc, w_ovf} !== {1'b1, 16'd5, 1'b0}) begin nbad++; $display("FAIL t3_first got=%b/%h/%b want=1/0005/0", w_valid, w_acc, w_ovf); end
    step(acc);
    r2 = 0;
    ntot++; if ({w_valid, s_valid} !== 2'b00) begin nbad++; $display("FAIL t3_drain got=%b want=00", {w_valid, s_valid}); end
  endtask

  task automatic test_credit();
    bit acc, saw_low;
    int nacc;
    logic [24:0] e;
    pipes = 3'd3; out_ready = 1'b0; nacc = 0; saw_low = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 16'(i * 5 + 3), 16'(i));
      step(acc);
      if (acc) nacc++; else saw_low = 1;
    end
    for (int i = 0; i < 4; i++) step(acc);
    ntot++; if (nacc != 8 || !saw_low) begin nbad++; $display("FAIL t4_credit accepted=%0d low=%0b want=8/1", nacc, saw_low); end
    ntot++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL t4_full_ready got=%0b want=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = (q.size() != 0) ? q.pop_front() : 'x;
      ntot++; if (out_valid !== 1'b1 || {acc_out, acc_ovf} !== e) begin nbad++; $display("FAIL t4_pop i=%0d got=%b/%h want=1/%h", i, out_valid, {acc_out, acc_ovf}, e); end
      step(acc);
    end
    out_ready = 1'b0;
    ntot++; if ({out_valid, in_ready} !== 2'b01) begin nbad++; $display("FAIL t4_empty got=%b want=01", {out_valid, in_ready}); end
  endtask

  task automatic test_reconfig();
    bit acc, got;
    int lowc, seen;
    logic [24:0] e;
    pipes = 3'd2; out_ready = 1'b1; lowc = 0; seen = 0; got = 0;
    drive(1, 1, 1, 16'd7, 16'd8);
    step(acc);
    drive(1, 1, 1, 16'd9, 16'd10);
    step(acc);
    pipes = 3'd3;
    for (int c = 0; c < 20 && !got; c++) begin
      if (out_valid === 1'b1) begin
        e = (q.size() != 0) ? q.pop_front() : 'x;
        seen++;
        ntot++; if ({acc_out, acc_ovf} !== e) begin nbad++; $display("FAIL t5_old got=%h want=%h", {acc_out, acc_ovf}, e); end
      end
      drive(1, 1, 1, 16'd40, 16'd2);
      step(acc);
      if (acc) got = 1; else lowc++;
    end
    ntot++; if (!got || lowc != 2 || seen != 2) begin nbad++; $display("FAIL t5_stall got=%0b low=%0d seen=%0d want=1/2/2", got, lowc, seen); end
    for (int i = 0; i < 2; i++) begin
      ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t5_early c=%0d got=%0b want=0", i, out_valid); end
      step(acc);
    end
    ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t5_early c=2 got=%0b want=0", out_valid); end
    step(acc);
    e = (q.size() != 0) ? q.pop_front() : 'x;
    ntot++; if (out_valid !== 1'b1 || {acc_out, acc_ovf} !== e || acc_out !== 24'd42) begin nbad++; $display("FAIL t5_new got=%b/%h want=1/%h", out_valid, {acc_out, acc_ovf}, e); end
    step(acc);
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit acc;
    logic [24:0] e;
    pipes = 3'd3; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 16'(i + 1), 16'd0);
      step(acc);
    end
    for (int i = 0; i < 4; i++) step(acc);
    drive(1, 1, 0, 16'd50, 16'd0); step(acc);
    drive(1, 0, 1, 16'd60, 16'd0); step(acc);
    ntot++; if (out_valid !== 1'b1) begin nbad++; $display("FAIL t6_pre got=%0b want=1", out_valid); end
    rst = 1'b1;
    step(acc);
    ntot++; if ({out_valid, acc_out, acc_ovf} !== 26'd0) begin nbad++; $display("FAIL t6_cleared got=%h want=0", {out_valid, acc_out, acc_ovf}); end
    step(acc);
    rst = 1'b0;
    #1;
    ntot++; if ({in_ready, out_valid} !== 2'b10) begin nbad++; $display("FAIL t6_release got=%b want=10", {in_ready, out_valid}); end
    q.delete();
    exp_acc = '0; exp_ovf = 1'b0;
    for (int i = 0; i < 8; i++) step(acc);
    ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL t6_stale got=%0b want=0", out_valid); end
    drive(1, 1, 1, 16'd5, 16'd6);
    step(acc);
    for (int i = 0; i < 3; i++) step(acc);
    e = (q.size() != 0) ? q.pop_front() : 'x;
    ntot++; if (out_valid !== 1'b1 || {acc_out, acc_ovf} !== e || acc_out !== 24'd11) begin nbad++; $display("FAIL t6_resume got=%b/%h want=1/%h", out_valid, {acc_out, acc_ovf}, e); end
  endtask

  initial begin
    test_reset();
    test_two_term();
    test_latency7();
    test_overflow();
    test_credit();
    test_reconfig();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
